// File: rtl/sram_scan_pkg.sv
// -----------------------------------------------------------------------------
// sram_scan_pkg
// Shared types and frame-geometry helpers for the spram scan-chain command
// stage (sram_scan_ctrl and sram_scan_shreg).
//
// Optional feature macro: SRAM_SCAN_PARITY_EN
//   When defined, every frame carries one trailing even-parity bit (the LSB).
//
// Frame layout, MSB to LSB:
//   op[1:0] | id_sel | seg_id[1:0] | addr[ADDR_W-1:0] | data[WIDTH-1:0] | [par]
// -----------------------------------------------------------------------------
package sram_scan_pkg;

`ifdef SRAM_SCAN_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  // Default spram geometry; cmd_t is laid out for these widths.
  localparam int SRAM_WIDTH  = 32;
  localparam int SRAM_ADDR_W = 11;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_RSVD  = 2'b11   // executes as NOP
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // Frame fields at the default geometry, MSB first.
  typedef struct packed {
    op_e                    op;
    logic                   id_sel;
    logic [1:0]             seg_id;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_WIDTH-1:0]  data;
`ifdef SRAM_SCAN_PARITY_EN
    logic                   par;
`endif
  } cmd_t;

  // Total scan frame length.
  function automatic int frame_w(input int addr_w, input int width);
    return 5 + addr_w + width + PAR_W;
  endfunction

  // Field LSB offsets inside the frame.
  function automatic int data_lsb();
    return PAR_W;
  endfunction

  function automatic int addr_lsb(input int width);
    return PAR_W + width;
  endfunction

  function automatic int seg_lsb(input int addr_w, input int width);
    return addr_lsb(width) + addr_w;
  endfunction

  function automatic int id_sel_bit(input int addr_w, input int width);
    return seg_lsb(addr_w, width) + 2;
  endfunction

  function automatic int op_lsb(input int addr_w, input int width);
    return id_sel_bit(addr_w, width) + 1;
  endfunction

endpackage

// File: rtl/sram_scan_shreg.sv
// -----------------------------------------------------------------------------
// sram_scan_shreg
// Scan register: serial shift-in at the LSB with parallel load. Load wins over
// shift; with neither asserted the register holds.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (clears the register)
//   shift_en     shift one bit: q <= {q[W-2:0], shift_in}
//   shift_in     serial input bit
//   load_en      parallel load of load_data
//   load_data    W-bit parallel load value
//   q            current register contents (q[W-1] is the serial output)
// -----------------------------------------------------------------------------
module sram_scan_shreg #(
  parameter int W = 48
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         shift_en,
  input  logic         shift_in,
  input  logic         load_en,
  input  logic [W-1:0] load_data,
  output logic [W-1:0] q
);

  // NOTE: this is a flop array, not a RAM macro, so every bit takes the
  // asynchronous reset; state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load_en) begin
      q <= load_data;
    end else if (shift_en) begin
      q <= {q[W-2:0], shift_in};
    end
  end

endmodule

// File: rtl/sram_scan_ctrl.sv
// -----------------------------------------------------------------------------
// sram_scan_ctrl
// Scan-chain command stage for spram. Frames are shifted in serially; a
// scan_update pulse in IDLE executes the frame as one single-cycle spram
// access (IDLE -> ISSUE -> WAIT -> DONE). Read data is captured in WAIT and
// placed back in the scan register (op cleared to NOP) for shift-out.
//
// Optional feature macro: SRAM_SCAN_PARITY_EN (trailing even-parity bit,
// sticky err flag, parity regenerated on read-back). Undefined: err = 0.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   scan_en/scan_in  serial shift (IDLE only), MSB of the frame first
//   scan_update      execute the frame in the scan register (IDLE, !scan_en)
//   scan_out         scan register MSB
//   busy, done       FSM not idle / one-cycle completion pulse
//   sram_*           spram access, non-zero only in the ISSUE cycle
//   sram_rdata       spram read data, valid the cycle after sram_ren
//   err              parity error flag
// -----------------------------------------------------------------------------
module sram_scan_ctrl
  import sram_scan_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_en,
  input  logic              scan_in,
  input  logic              scan_update,
  output logic              scan_out,
  output logic              busy,
  output logic              done,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic              sram_ren,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [WIDTH-1:0]  sram_wdata,
  output logic [1:0]        sram_seg_id,
  output logic              sram_id_sel,
  input  logic [WIDTH-1:0]  sram_rdata,
  output logic              err
);

  localparam int FRAME_W  = frame_w(ADDR_W, WIDTH);
  localparam int DATA_LSB = data_lsb();
  localparam int ADDR_LSB = addr_lsb(WIDTH);
  localparam int SEG_LSB  = seg_lsb(ADDR_W, WIDTH);
  localparam int ID_BIT   = id_sel_bit(ADDR_W, WIDTH);
  localparam int OP_LSB   = op_lsb(ADDR_W, WIDTH);

  state_e               state_q, state_d;
  logic [FRAME_W-1:0]   sreg, sreg_load;
  op_e                  frame_op;
  logic                 frame_ok;
  logic                 accept;
  logic                 issue_go;
  logic                 shift_en;
  logic                 load_en;

  // Command register: what the in-flight command needs after ISSUE.
  op_e                  cmd_op_q;
  logic                 cmd_ok_q;

  assign frame_op = op_e'(sreg[OP_LSB +: 2]);

`ifdef SRAM_SCAN_PARITY_EN
  assign frame_ok = ~^sreg;   // even parity over the whole frame
`else
  assign frame_ok = 1'b1;
`endif

  // An update coinciding with a shift is dropped; both are ignored when busy.
  assign accept   = (state_q == ST_IDLE) && scan_update && !scan_en;
  assign issue_go = accept && frame_ok;
  assign shift_en = (state_q == ST_IDLE) && scan_en;
  assign load_en  = (state_q == ST_WAIT) && (cmd_op_q == OP_READ) && cmd_ok_q;

  // Read-back frame: op cleared, data replaced, parity regenerated.
  always_comb begin
    sreg_load                       = sreg;
    sreg_load[OP_LSB +: 2]          = 2'b00;
    sreg_load[DATA_LSB +: WIDTH]    = sram_rdata;
`ifdef SRAM_SCAN_PARITY_EN
    sreg_load[0]                    = ^sreg_load[FRAME_W-1:1];
`endif
  end

  sram_scan_shreg #(
    .W (FRAME_W)
  ) u_shreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift_en  (shift_en),
    .shift_in  (scan_in),
    .load_en   (load_en),
    .load_data (sreg_load),
    .q         (sreg)
  );

  assign scan_out = sreg[FRAME_W-1];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: state_d gets its default before the case so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Registered outputs and command register. The spram drive is loaded on the
  // IDLE->ISSUE edge straight from the scan register, so it is present exactly
  // during the ISSUE cycle and cleared on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      sram_cen    <= 1'b0;
      sram_wen    <= 1'b0;
      sram_ren    <= 1'b0;
      sram_addr   <= '0;
      sram_wdata  <= '0;
      sram_seg_id <= '0;
      sram_id_sel <= 1'b0;
      cmd_op_q    <= OP_NOP;
      cmd_ok_q    <= 1'b0;
`ifdef SRAM_SCAN_PARITY_EN
      err         <= 1'b0;
`endif
    end else begin
      busy        <= (state_d != ST_IDLE);
      done        <= (state_d == ST_DONE);
      sram_cen    <= issue_go;
      sram_wen    <= issue_go && (frame_op == OP_WRITE);
      sram_ren    <= issue_go && (frame_op == OP_READ);
      sram_addr   <= issue_go ? sreg[ADDR_LSB +: ADDR_W] : '0;
      sram_wdata  <= issue_go ? sreg[DATA_LSB +: WIDTH]  : '0;
      sram_seg_id <= issue_go ? sreg[SEG_LSB +: 2]       : '0;
      sram_id_sel <= issue_go && sreg[ID_BIT];
      if (accept) begin
        cmd_op_q <= frame_op;
        cmd_ok_q <= frame_ok;
`ifdef SRAM_SCAN_PARITY_EN
        err      <= !frame_ok;   // sticky until the next accepted update
`endif
      end
    end
  end

`ifndef SRAM_SCAN_PARITY_EN
  assign err = 1'b0;
`endif

endmodule
